// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/condition/execute/memory/writeback control FSM that owns the PC and IR.
// Latency: DP 5, branch 4, load 6 cycles plus bus wait; bus requests are held until ack or timeout (sticky FAULT).
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_ack,
    input  logic [31:0] instr_rdata,
    output logic [31:0] ir,
    output logic        dec_enable,
    input  logic        dec_valid,
    input  logic [3:0]  flags_nzcv,
    output logic        exec_en,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        undef,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_CHECK  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    state_t        cur_state, nxt_state;
    logic [31:0]   pc_q, pc_nxt, ir_q, ir_nxt;
    logic [TW-1:0] tcnt_q, tcnt_nxt;
    logic [2:0]    iclass;
    logic          class_ok, cond_ok, is_branch, is_ls, bus_expired;
    logic [31:0]   br_off;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cy;
            4'h3:    cond_pass = !cy;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cy & !z;
            4'h9:    cond_pass = !cy | z;
            4'ha:    cond_pass = (n == v);
            4'hb:    cond_pass = (n != v);
            4'hc:    cond_pass = !z & (n == v);
            4'hd:    cond_pass = z | (n != v);
            4'he:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign iclass      = ir_q[27:25];
    assign class_ok    = (iclass inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
    assign is_branch   = (iclass == 3'b101);
    assign is_ls       = (iclass[2:1] == 2'b01);
    assign cond_ok     = cond_pass(ir_q[31:28], flags_nzcv);
    assign br_off      = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    assign bus_expired = (tcnt_q == TW'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            tcnt_q    <= '0;
        end else begin
            cur_state <= nxt_state;
            pc_q      <= pc_nxt;
            ir_q      <= ir_nxt;
            tcnt_q    <= tcnt_nxt;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        pc_nxt     = pc_q;
        ir_nxt     = ir_q;
        tcnt_nxt   = tcnt_q;
        instr_req  = 1'b0;
        dec_enable = 1'b0;
        exec_en    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        wb_en      = 1'b0;
        lr_we      = 1'b0;
        retire     = 1'b0;
        undef      = 1'b0;
        fault      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (!halt) begin
                    // Gated by rst_n so the request drops the instant reset asserts.
                    instr_req = rst_n;
                    if (instr_ack) begin
                        ir_nxt    = instr_rdata;
                        nxt_state = S_DECODE;
                    end else if (bus_expired) begin
                        nxt_state = S_FAULT;
                    end else begin
                        tcnt_nxt = tcnt_q + TW'(1);
                    end
                end
            end
            S_DECODE: begin
                dec_enable = 1'b1;
                nxt_state  = S_CHECK;
            end
            S_CHECK: begin
                if (!dec_valid || !class_ok) begin
                    undef     = 1'b1;
                    retire    = 1'b1;
                    pc_nxt    = pc_q + 32'd4;
                    nxt_state = S_FETCH;
                end else if (!cond_ok) begin
                    retire    = 1'b1;
                    pc_nxt    = pc_q + 32'd4;
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (is_branch) begin
                    pc_nxt    = pc_q + 32'd8 + br_off;
                    lr_we     = ir_q[24];
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (is_ls) begin
                    nxt_state = S_MEM;
                end else if (ir_q[24:23] == 2'b10) begin
                    // TST/TEQ/CMP/CMN only update flags: nothing to write back.
                    retire    = 1'b1;
                    pc_nxt    = pc_q + 32'd4;
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req = rst_n;
                mem_we  = ~ir_q[20];
                if (mem_ack) begin
                    if (ir_q[20] || ir_q[21] || !ir_q[24]) begin
                        nxt_state = S_WB;
                    end else begin
                        retire    = 1'b1;
                        pc_nxt    = pc_q + 32'd4;
                        nxt_state = S_FETCH;
                    end
                end else if (bus_expired) begin
                    nxt_state = S_FAULT;
                end else begin
                    tcnt_nxt = tcnt_q + TW'(1);
                end
            end
            S_WB: begin
                wb_en     = 1'b1;
                retire    = 1'b1;
                pc_nxt    = pc_q + 32'd4;
                nxt_state = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                nxt_state = S_FAULT;
            end
        endcase
        // Every state change starts a fresh bus-wait window.
        if (nxt_state != cur_state) begin
            tcnt_nxt = '0;
        end
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign lr_wdata   = lr_we ? pc_q + 32'd4 : 32'd0;
    assign state      = cur_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed and randomized instruction sequences checked against an outcome-level reference model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, halt, instr_req, instr_ack, dec_enable, dec_valid;
    logic        exec_en, mem_req, mem_we, mem_ack, wb_en, lr_we, retire, undef, fault;
    logic [31:0] instr_addr, instr_rdata, ir, lr_wdata, pc;
    logic [3:0]  flags_nzcv;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(32'h0), .BUS_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
        .instr_rdata(instr_rdata), .ir(ir), .dec_enable(dec_enable), .dec_valid(dec_valid),
        .flags_nzcv(flags_nzcv), .exec_en(exec_en), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .wb_en(wb_en), .lr_we(lr_we), .lr_wdata(lr_wdata), .pc(pc),
        .retire(retire), .undef(undef), .fault(fault), .state(state)
    );

    typedef struct {
        int          dec, exe, wb, lr, ret, und, memc, cyc, consec;
        logic        we;
        logic [31:0] pc, lrd;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0: return z;          4'd1: return !z;
            4'd2: return cy;         4'd3: return !cy;
            4'd4: return n;          4'd5: return !n;
            4'd6: return v;          4'd7: return !v;
            4'd8: return cy && !z;   4'd9: return !cy || z;
            4'd10: return n == v;    4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outcome of one instruction from the architectural rules, given bus wait times.
    function automatic obs_t model(input logic [31:0] in, input logic [3:0] f, input logic dv,
                                   input int aw, input int mw);
        obs_t e;
        int   cls;
        e = '{default: 0};
        cls   = int'(in[27:25]);
        e.dec = 1;
        e.ret = 1;
        e.cyc = aw + 3;
        e.pc  = m_pc + 32'd4;
        if (!dv || !(cls inside {0, 1, 2, 3, 5})) begin
            e.und = 1;
        end else if (cond_holds(in[31:28], f)) begin
            e.exe = 1;
            e.cyc += 1;
            if (cls == 5) begin
                e.pc = m_pc + 32'd8 + (32'($signed(in[23:0])) << 2);
                if (in[24]) begin
                    e.lr  = 1;
                    e.lrd = m_pc + 32'd4;
                end
            end else if (cls == 2 || cls == 3) begin
                e.memc = mw + 1;
                e.cyc += mw + 1;
                e.we   = !in[20];
                if (in[20] || in[21] || !in[24]) begin
                    e.wb = 1;
                    e.cyc += 1;
                end
            end else if (in[24:23] != 2'b10) begin
                e.wb = 1;
                e.cyc += 1;
            end
        end
        return e;
    endfunction

    task automatic run(input string tag, input logic [31:0] in, input logic [3:0] f,
                       input logic dv, input int aw, input int mw);
        obs_t o, e;
        int   fc, mc;
        bit   done;
        logic [5:0] strb, prev;
        e = model(in, f, dv, aw, mw);
        o = '{default: 0};
        fc = 0; mc = 0; done = 0; prev = '0;
        instr_rdata = in; flags_nzcv = f; dec_valid = dv;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            instr_ack = instr_req && (fc == aw);
            mem_ack   = mem_req && (mc == mw);
            #1;
            o.cyc++;
            if (instr_req) begin
                if (fc == 0) chk({tag, ".addr"}, instr_addr, m_pc);
                if (!instr_ack) fc++;
            end
            if (mem_req) begin
                o.memc++;
                o.we = mem_we;
                if (!mem_ack) mc++;
            end
            o.dec += int'(dec_enable);
            o.exe += int'(exec_en);
            o.wb  += int'(wb_en);
            o.lr  += int'(lr_we);
            o.ret += int'(retire);
            o.und += int'(undef);
            if (lr_we) o.lrd = lr_wdata;
            strb = {dec_enable, exec_en, wb_en, lr_we, retire, undef};
            if ((strb & prev) != 0) o.consec++;
            prev = strb;
            if (retire) done = 1;
            if (fault) break;
        end
        chk({tag, ".retired"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        o.pc = pc;
        chk({tag, ".pc"}, o.pc, e.pc);
        chk({tag, ".cycles"}, o.cyc, e.cyc);
        chk({tag, ".dec_enable"}, o.dec, e.dec);
        chk({tag, ".exec_en"}, o.exe, e.exe);
        chk({tag, ".wb_en"}, o.wb, e.wb);
        chk({tag, ".lr_we"}, o.lr, e.lr);
        chk({tag, ".lr_wdata"}, o.lrd, e.lrd);
        chk({tag, ".retire"}, o.ret, e.ret);
        chk({tag, ".undef"}, o.und, e.und);
        chk({tag, ".mem_cycles"}, o.memc, e.memc);
        chk({tag, ".mem_we"}, 32'(o.we), 32'(e.we));
        chk({tag, ".strobe_repeat"}, o.consec, 0);
        m_pc = e.pc;
    endtask

    initial begin
        logic [31:0] in, pc_hold;
        int          n;
        rst_n = 1'b0; halt = 1'b0; instr_ack = 1'b0; mem_ack = 1'b0;
        instr_rdata = '0; dec_valid = 1'b1; flags_nzcv = '0;
        m_pc = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.pc", pc, 32'h0);
        chk("rst.instr_req", 32'(instr_req), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.ir", ir, 32'h0);
        chk("rst.lr_wdata", lr_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("b_to_100", 32'hEA00003E, 4'h0, 1'b1, 0, 0);
        run("bl", 32'hEB000002, 4'h0, 1'b1, 0, 0);
        run("add", 32'hE0821003, 4'h0, 1'b1, 0, 0);
        run("beq_nt", 32'h0A000004, 4'h0, 1'b1, 1, 0);
        run("beq_t", 32'h0A000004, 4'h4, 1'b1, 0, 0);
        run("cmp", 32'hE1510002, 4'h0, 1'b1, 0, 0);
        run("ldr", 32'hE5912004, 4'h0, 1'b1, 0, 3);
        run("str", 32'hE5812004, 4'h0, 1'b1, 2, 2);
        run("undef_dv", 32'hE6000010, 4'h0, 1'b0, 0, 0);
        run("undef_cls", 32'hE8000000, 4'h0, 1'b1, 0, 0);
        run("never", 32'hF0821003, 4'hF, 1'b1, 0, 0);
        run("ack_at_limit", 32'hE0821003, 4'h0, 1'b1, 15, 0);
        run("mem_at_limit", 32'hE5912004, 4'h0, 1'b1, 0, 15);

        @(negedge clk);
        halt = 1'b1;
        #1;
        chk("halt.instr_req", 32'(instr_req), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("halt.state", 32'(state), 32'd0);
        chk("halt.pc", pc, m_pc);
        halt = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0] cls_pick [8];
            cls_pick = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd4, 3'd7};
            in = $urandom;
            in[27:25] = cls_pick[$urandom_range(0, 7)];
            run($sformatf("rnd%0d", i), in, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        n = 0;
        instr_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (fault) break;
            if (instr_req) n++;
        end
        chk("timeout.req_cycles", n, 16);
        chk("timeout.fault", 32'(fault), 32'd1);
        chk("timeout.state", 32'(state), 32'd7);
        chk("timeout.instr_req", 32'(instr_req), 32'd0);
        pc_hold = pc;
        chk("timeout.pc", pc_hold, m_pc);
        repeat (3) @(negedge clk);
        #1;
        chk("fault.sticky", 32'(fault), 32'd1);
        chk("fault.pc_frozen", pc, m_pc);
        chk("fault.retire", 32'(retire), 32'd0);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pc", pc, 32'h0);
        chk("arst.fault", 32'(fault), 32'd0);
        chk("arst.instr_req", 32'(instr_req), 32'd0);
        chk("arst.state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0;
        run("post_rst", 32'hE0821003, 4'h0, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
